wb_line_master: RTL and testbench

// - Wishbone master issuing 512-bit (64-byte) cache-line reads/writes to the DDR3 Wishbone slave wrapper.
// - Sits between the cache controller (request/response port) and the DDR3 slave, in the DDR3 ui clock domain.
// - Holds one outstanding transfer; aligns addresses to 64 B; returns read line data and completion status.

---
 rtl/wb_line_master_if.sv | 47 ++++
 rtl/wb_line_master.sv | 146 ++++++++++++++
 tb/tb_wb_line_master.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_line_master_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : wb_line_master_if                                          |
// | Description : Signal bundle between the cache controller, the line       |
// |               master and the DDR3 Wishbone slave wrapper. It carries the |
// |               request/response port (req_*, resp_*) and the 512-bit      |
// |               Wishbone bus (wm_*).                                       |
// | Modports    : master - the view used by wb_line_master                   |
// |               slave  - the view of the cache controller plus the DDR3    |
// |                        slave, i.e. everything facing the master          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface wb_line_master_if;
    // Cache-side request
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [31:0]  req_addr;
    logic [511:0] req_wdata;
    logic [63:0]  req_wmask;
    // Cache-side response
    logic         resp_valid;
    logic [511:0] resp_rdata;
    logic         resp_err;
    // Wishbone bus towards the DDR3 slave
    logic         wm_cyc;
    logic         wm_stb;
    logic         wm_we;
    logic [31:0]  wm_addr;
    logic [511:0] wm_dout;
    logic [63:0]  wm_dm;
    logic         wm_ack;
    logic [511:0] wm_din;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask, wm_ack, wm_din,
        output req_ready, resp_valid, resp_rdata, resp_err,
               wm_cyc, wm_stb, wm_we, wm_addr, wm_dout, wm_dm
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_wmask, wm_ack, wm_din,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               wm_cyc, wm_stb, wm_we, wm_addr, wm_dout, wm_dm
    );
endinterface
`default_nettype wire

// File: rtl/wb_line_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : wb_line_master                                             |
// | Description : Wishbone master issuing 64-byte cache-line reads/writes to |
// |               the DDR3 Wishbone slave wrapper. One transfer outstanding; |
// |               addresses are aligned down to 64 B; read data and a        |
// |               completion status are returned as a one-cycle pulse.       |
// | Ports       : clk  - DDR3 ui clock                                       |
// |               rst  - synchronous reset, active-high                      |
// |               bus  - wb_line_master_if.master                            |
// |                      req_valid/req_ready/req_we/req_addr/req_wdata/      |
// |                      req_wmask in, resp_valid/resp_rdata/resp_err out,   |
// |                      wm_cyc/stb/we/addr/dout/dm out, wm_ack/wm_din in    |
// | Parameters  : TIMEOUT_CYCLES - un-acked BUS cycles before abort          |
// |               TO_W           - timeout counter width,                    |
// |                                2**TO_W > TIMEOUT_CYCLES                  |
// | Option      : WB_LINE_MASTER_TIMEOUT_EN - when defined, a bus cycle left |
// |               un-acked for TIMEOUT_CYCLES is aborted with resp_err=1 and |
// |               all-ones read data; otherwise BUS waits indefinitely.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module wb_line_master #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 13
) (
    input  wire                      clk,
    input  wire                      rst,
    wb_line_master_if.master         bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_cyc;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [511:0]  r_dout;
    logic [63:0]   r_dm;
    logic          r_resp_valid;
    logic [511:0]  r_rdata;

`ifdef WB_LINE_MASTER_TIMEOUT_EN
    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;
`endif

    // The low six address bits are discarded by the 64-byte alignment.
    logic w_unused_addr;
    assign w_unused_addr = ^bus.req_addr[5:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cyc        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_dout       <= '0;
            r_dm         <= '0;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
`ifdef WB_LINE_MASTER_TIMEOUT_EN
            r_to_cnt     <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_cyc   <= 1'b1;
                        r_we    <= bus.req_we;
                        r_addr  <= {bus.req_addr[31:6], 6'b0};
                        r_dout  <= bus.req_wdata;
                        r_dm    <= bus.req_wmask;
                        r_state <= S_BUS;
`ifdef WB_LINE_MASTER_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                    end
                end

                S_BUS: begin
                    // Ack takes priority over expiry in the same cycle.
                    if (bus.wm_ack) begin
                        r_cyc        <= 1'b0;
                        r_we         <= 1'b0;
                        r_resp_valid <= 1'b1;
                        if (!r_we) begin
                            r_rdata <= bus.wm_din;
                        end
                        r_state <= S_RESP;
`ifdef WB_LINE_MASTER_TIMEOUT_EN
                        r_err   <= 1'b0;
                    end else if (r_to_cnt == c_TO_LAST) begin
                        r_cyc        <= 1'b0;
                        r_we         <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_rdata      <= '1;
                        r_err        <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
`endif
                    end
                end

                S_RESP: begin
                    // resp_valid was raised on entry; it drops on this edge.
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cyc   <= 1'b0;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.wm_cyc     = r_cyc;
    assign bus.wm_stb     = r_cyc;
    assign bus.wm_we      = r_we;
    assign bus.wm_addr    = r_addr;
    assign bus.wm_dout    = r_dout;
    assign bus.wm_dm      = r_dm;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_rdata;

`ifdef WB_LINE_MASTER_TIMEOUT_EN
    assign bus.resp_err   = r_err;
`else
    assign bus.resp_err   = 1'b0;
    // Timeout parameters only shape hardware when the timeout option is built.
    logic w_unused_params;
    assign w_unused_params = TIMEOUT_CYCLES[0] ^ TO_W[0];
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_line_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_wb_line_master                                          |
// | Description : Directed self-checking bench for wb_line_master. The bench |
// |               plays both the cache controller and the DDR3 slave through |
// |               the slave modport view of the interface.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_wb_line_master;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    wb_line_master_if bus ();

    wb_line_master #(
        .TIMEOUT_CYCLES (16),
        .TO_W           (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [511:0] c_A5 = {64{8'hA5}};
    localparam logic [511:0] c_5A = {64{8'h5A}};
    localparam logic [511:0] c_C3 = {64{8'hC3}};
    localparam logic [511:0] c_3C = {64{8'h3C}};
    localparam logic [511:0] c_77 = {64{8'h77}};
    localparam logic [511:0] c_WD = {16{32'hDEAD_BEEF}};

    // Present a request and hold it until the edge that accepts it.
    task automatic issue(input logic we, input logic [31:0] a,
                         input logic [511:0] d, input logic [63:0] m);
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wmask = m;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    // Single-cycle slave acknowledge, sampled on the second posedge.
    task automatic pulse_ack(input logic [511:0] din);
        @(posedge clk); #1;
        bus.wm_ack = 1'b1;
        bus.wm_din = din;
        @(posedge clk); #1;
        bus.wm_ack = 1'b0;
        bus.wm_din = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.wm_cyc, bus.wm_stb, bus.wm_we, bus.resp_valid, bus.resp_err} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 100000", {bus.req_ready, bus.wm_cyc, bus.wm_stb, bus.wm_we, bus.resp_valid, bus.resp_err});
        end
        checks++;
        if (bus.wm_addr !== 32'h0 || bus.wm_dm !== 64'h0 || bus.wm_dout !== 512'h0 || bus.resp_rdata !== 512'h0) begin
            errors++;
            $display("FAIL reset_data: addr %h dm %h not all zero", bus.wm_addr, bus.wm_dm);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_read;
        issue(1'b0, 32'h0000_1234, c_WD, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        checks++;
        if ({bus.wm_cyc, bus.wm_stb, bus.wm_we, bus.req_ready} !== 4'b1100) begin
            errors++;
            $display("FAIL read_start: cyc/stb/we/ready got %b expected 1100", {bus.wm_cyc, bus.wm_stb, bus.wm_we, bus.req_ready});
        end
        checks++;
        if (bus.wm_addr !== 32'h0000_1200) begin
            errors++;
            $display("FAIL read_addr: got %h expected 00001200", bus.wm_addr);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.wm_cyc !== 1'b1 || bus.resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL read_hold%0d: cyc %b resp_valid %b expected 1 0", i, bus.wm_cyc, bus.resp_valid);
            end
        end
        pulse_ack(c_A5);
        @(negedge clk);
        checks++;
        if ({bus.resp_valid, bus.resp_err, bus.wm_cyc} !== 3'b100 || bus.resp_rdata !== c_A5) begin
            errors++;
            $display("FAIL read_resp: valid/err/cyc %b expected 100, rdata %h", {bus.resp_valid, bus.resp_err, bus.wm_cyc}, bus.resp_rdata);
        end
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL read_pulse_end: resp_valid %b ready %b expected 0 1", bus.resp_valid, bus.req_ready);
        end
    endtask

    task automatic test_write;
        issue(1'b1, 32'h8000_0040, c_WD, 64'h0000_0000_0000_FFFF);
        @(negedge clk);
        checks++;
        if ({bus.wm_cyc, bus.wm_stb, bus.wm_we} !== 3'b111 || bus.wm_addr !== 32'h8000_0040) begin
            errors++;
            $display("FAIL write_start: cyc/stb/we %b addr %h expected 111 80000040", {bus.wm_cyc, bus.wm_stb, bus.wm_we}, bus.wm_addr);
        end
        checks++;
        if (bus.wm_dm !== 64'h0000_0000_0000_FFFF || bus.wm_dout !== c_WD) begin
            errors++;
            $display("FAIL write_data: dm %h expected 000000000000ffff", bus.wm_dm);
        end
        pulse_ack(c_5A);
        @(negedge clk);
        checks++;
        if ({bus.resp_valid, bus.resp_err, bus.wm_cyc, bus.wm_we} !== 4'b1000 || bus.resp_rdata !== c_A5) begin
            errors++;
            $display("FAIL write_resp: valid/err/cyc/we %b expected 1000, rdata %h", {bus.resp_valid, bus.resp_err, bus.wm_cyc, bus.wm_we}, bus.resp_rdata);
        end
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL write_pulse_end: resp_valid %b expected 0", bus.resp_valid);
        end
    endtask

    task automatic test_back_to_back;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h0000_0100;
        bus.req_wdata = c_WD;
        bus.req_wmask = 64'hFF00_FF00_FF00_FF00;
        @(posedge clk); #1;
        // First request accepted; present the read while keeping req_valid high.
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0000_023F;
        @(negedge clk);
        checks++;
        if ({bus.wm_cyc, bus.wm_we} !== 2'b11 || bus.wm_addr !== 32'h0000_0100 || bus.wm_dm !== 64'hFF00_FF00_FF00_FF00) begin
            errors++;
            $display("FAIL b2b_first: cyc/we %b addr %h dm %h", {bus.wm_cyc, bus.wm_we}, bus.wm_addr, bus.wm_dm);
        end
        pulse_ack(c_77);
        @(negedge clk);
        checks++;
        if ({bus.resp_valid, bus.wm_cyc, bus.req_ready} !== 3'b100 || bus.resp_rdata !== c_A5) begin
            errors++;
            $display("FAIL b2b_resp1: valid/cyc/ready %b expected 100, rdata %h", {bus.resp_valid, bus.wm_cyc, bus.req_ready}, bus.resp_rdata);
        end
        @(negedge clk);
        checks++;
        if ({bus.resp_valid, bus.wm_cyc, bus.req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL b2b_gap: valid/cyc/ready %b expected 001", {bus.resp_valid, bus.wm_cyc, bus.req_ready});
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.wm_cyc, bus.wm_we} !== 2'b10 || bus.wm_addr !== 32'h0000_0200) begin
            errors++;
            $display("FAIL b2b_second: cyc/we %b addr %h expected 10 00000200", {bus.wm_cyc, bus.wm_we}, bus.wm_addr);
        end
        pulse_ack(c_C3);
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== c_C3) begin
            errors++;
            $display("FAIL b2b_resp2: valid %b rdata %h expected 1 c3..c3", bus.resp_valid, bus.resp_rdata);
        end
    endtask

    task automatic test_stray_ack;
        @(negedge clk);
        pulse_ack(c_77);
        @(negedge clk);
        checks++;
        if ({bus.resp_valid, bus.wm_cyc, bus.req_ready} !== 3'b001 || bus.resp_rdata !== c_C3) begin
            errors++;
            $display("FAIL stray_ignored: valid/cyc/ready %b expected 001, rdata %h", {bus.resp_valid, bus.wm_cyc, bus.req_ready}, bus.resp_rdata);
        end
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_late: resp_valid %b expected 0", bus.resp_valid);
        end
        issue(1'b0, 32'h0000_0040, c_WD, 64'h1);
        @(negedge clk);
        checks++;
        if (bus.wm_cyc !== 1'b1 || bus.wm_addr !== 32'h0000_0040) begin
            errors++;
            $display("FAIL stray_read_start: cyc %b addr %h expected 1 00000040", bus.wm_cyc, bus.wm_addr);
        end
        pulse_ack(c_3C);
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== c_3C || bus.resp_err !== 1'b0) begin
            errors++;
            $display("FAIL stray_read_resp: valid %b err %b rdata %h", bus.resp_valid, bus.resp_err, bus.resp_rdata);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        issue(1'b0, 32'h0000_1000, c_WD, 64'h0);
        @(negedge clk);
        checks++;
        if (bus.wm_cyc !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_start: cyc %b expected 1", bus.wm_cyc);
        end
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.wm_cyc, bus.wm_stb, bus.req_ready, bus.resp_valid} !== 4'b0010 || bus.resp_rdata !== 512'h0) begin
            errors++;
            $display("FAIL rstmid_release: cyc/stb/ready/valid %b expected 0010", {bus.wm_cyc, bus.wm_stb, bus.req_ready, bus.resp_valid});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.resp_valid !== 1'b0 || bus.wm_cyc !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_quiet%0d: valid %b cyc %b expected 0 0", i, bus.resp_valid, bus.wm_cyc);
            end
        end
    endtask

    task automatic test_timeout;
        int n;
        issue(1'b0, 32'h0000_2000, c_WD, 64'h0);
        n = 0;
`ifdef WB_LINE_MASTER_TIMEOUT_EN
        @(negedge clk);
        while (bus.wm_cyc === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL timeout_len: bus held %0d cycles expected 16", n);
        end
        checks++;
        if ({bus.resp_valid, bus.resp_err} !== 2'b11 || bus.resp_rdata !== {512{1'b1}}) begin
            errors++;
            $display("FAIL timeout_resp: valid/err %b expected 11, rdata %h", {bus.resp_valid, bus.resp_err}, bus.resp_rdata);
        end
`else
        repeat (40) begin
            @(negedge clk);
            if (bus.wm_cyc === 1'b1 && bus.resp_valid === 1'b0) n++;
        end
        checks++;
        if (n != 40) begin
            errors++;
            $display("FAIL no_timeout_wait: bus held %0d of 40 cycles", n);
        end
        pulse_ack(c_5A);
        @(negedge clk);
        checks++;
        if ({bus.resp_valid, bus.resp_err} !== 2'b10 || bus.resp_rdata !== c_5A) begin
            errors++;
            $display("FAIL no_timeout_resp: valid/err %b expected 10, rdata %h", {bus.resp_valid, bus.resp_err}, bus.resp_rdata);
        end
`endif
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_end: valid %b ready %b expected 0 1", bus.resp_valid, bus.req_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
        bus.wm_ack    = 1'b0;
        bus.wm_din    = '0;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_stray_ack();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
